// File: rtl/i2c_apb_sequencer.sv
// APB master that runs single-byte I2C register reads/writes on the I2C master core for a req/rsp client.
// Optional STATUS-poll timeout with core abort: define I2C_SEQ_TIMEOUT_EN.
module i2c_apb_sequencer #(
  parameter int DATA_SIZE    = 8,
  parameter int ADDR_SIZE    = 8,
  parameter     PRESCALE_VAL = 8'd4,
  parameter int POLL_LIMIT   = 1024
) (
  input  logic                 pclk_i,
  input  logic                 preset_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_rw_i,
  input  logic [6:0]           req_slave_addr_i,
  input  logic [7:0]           req_reg_addr_i,
  input  logic [DATA_SIZE-1:0] req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [DATA_SIZE-1:0] rsp_rdata_o,
  output logic                 rsp_err_o,
  output logic [ADDR_SIZE-1:0] paddr_o,
  output logic                 pwrite_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic [DATA_SIZE-1:0] pwdata_o,
  input  logic [DATA_SIZE-1:0] prdata_i,
  input  logic                 pready_i
);
  localparam logic [7:0] A_PRESCALE = 8'h00;
  localparam logic [7:0] A_CMD      = 8'h01;
  localparam logic [7:0] A_SLV      = 8'h02;
  localparam logic [7:0] A_TX       = 8'h03;
  localparam logic [7:0] A_RX       = 8'h04;
  localparam logic [7:0] A_STATUS   = 8'h05;
  localparam logic [DATA_SIZE-1:0] PRESCALE_T = DATA_SIZE'(PRESCALE_VAL);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_EXEC, S_RESP} state_t;
  typedef enum logic [1:0] {P_GAP, P_SETUP, P_ACCESS} phase_t;
  typedef enum logic [1:0] {OP_WR, OP_POLL, OP_RD} op_kind_t;

  state_t               state;
  phase_t               phase;
  logic [2:0]           step;
  logic                 rq_rw;
  logic [6:0]           rq_slv;
  logic [7:0]           rq_reg;
  logic [DATA_SIZE-1:0] rq_wdata;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int POLL_LIM = (POLL_LIMIT < 1) ? 1 : POLL_LIMIT;
  localparam int PCW      = $clog2(POLL_LIM + 1);
  logic           abort_r;
  logic [PCW-1:0] poll_cnt;
`endif

  op_kind_t             op_kind;
  logic [7:0]           op_addr;
  logic [DATA_SIZE-1:0] op_data;
  logic                 op_last;

  // Op decode: INIT prescale, abort write, else the write/read op list indexed by step.
  always_comb begin
    op_kind = OP_WR;
    op_addr = A_SLV;
    op_data = DATA_SIZE'({rq_slv, 1'b0});
    op_last = 1'b0;
    if (state == S_INIT) begin
      op_addr = A_PRESCALE;
      op_data = PRESCALE_T;
    end
`ifdef I2C_SEQ_TIMEOUT_EN
    else if (abort_r) begin
      op_addr = A_CMD;
      op_data = '0;
    end
`endif
    else if (!rq_rw) begin
      case (step)
        3'd1: begin op_addr = A_TX;  op_data = DATA_SIZE'(rq_reg); end
        3'd2: begin op_addr = A_TX;  op_data = rq_wdata; end
        3'd3: begin op_addr = A_CMD; op_data = DATA_SIZE'(8'h01); end
        3'd4: begin op_kind = OP_POLL; op_addr = A_STATUS; op_last = 1'b1; end
        default: ;
      endcase
    end else begin
      case (step)
        3'd1: begin op_addr = A_TX;  op_data = DATA_SIZE'(rq_reg); end
        3'd2: begin op_addr = A_CMD; op_data = DATA_SIZE'(8'h05); end
        3'd3: begin op_kind = OP_POLL; op_addr = A_STATUS; end
        3'd4: op_data = DATA_SIZE'({rq_slv, 1'b1});
        3'd5: begin op_addr = A_CMD; op_data = DATA_SIZE'(8'h03); end
        3'd6: begin op_kind = OP_POLL; op_addr = A_STATUS; end
        3'd7: begin op_kind = OP_RD; op_addr = A_RX; op_last = 1'b1; end
        default: ;
      endcase
    end
  end

  always_ff @(posedge pclk_i or posedge preset_i) begin
    if (preset_i) begin
      state       <= S_INIT;
      phase       <= P_GAP;
      step        <= '0;
      rq_rw       <= 1'b0;
      rq_slv      <= '0;
      rq_reg      <= '0;
      rq_wdata    <= '0;
      req_ready_o <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
      paddr_o     <= '0;
      pwrite_o    <= 1'b0;
      psel_o      <= 1'b0;
      penable_o   <= 1'b0;
      pwdata_o    <= '0;
`ifdef I2C_SEQ_TIMEOUT_EN
      abort_r     <= 1'b0;
      poll_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid_i && req_ready_o) begin
            rq_rw       <= req_rw_i;
            rq_slv      <= req_slave_addr_i;
            rq_reg      <= req_reg_addr_i;
            rq_wdata    <= req_wdata_i;
            req_ready_o <= 1'b0;
            step        <= '0;
            state       <= S_EXEC;
          end
        end
        S_RESP: begin
          rsp_valid_o <= 1'b0;
          req_ready_o <= 1'b1;
          state       <= S_IDLE;
        end
        default: begin
          case (phase)
            P_GAP: begin
              psel_o    <= 1'b1;
              penable_o <= 1'b0;
              paddr_o   <= ADDR_SIZE'(op_addr);
              pwrite_o  <= (op_kind == OP_WR);
              pwdata_o  <= (op_kind == OP_WR) ? op_data : '0;
              phase     <= P_SETUP;
            end
            P_SETUP: begin
              penable_o <= 1'b1;
              phase     <= P_ACCESS;
            end
            default: begin
              if (pready_i) begin
                psel_o    <= 1'b0;
                penable_o <= 1'b0;
                phase     <= P_GAP;
                if (state == S_INIT) begin
                  state       <= S_IDLE;
                  req_ready_o <= 1'b1;
                end
`ifdef I2C_SEQ_TIMEOUT_EN
                else if (abort_r) begin
                  abort_r     <= 1'b0;
                  state       <= S_RESP;
                  rsp_valid_o <= 1'b1;
                  rsp_err_o   <= 1'b1;
                  rsp_rdata_o <= '0;
                end
`endif
                else begin
                  case (op_kind)
                    OP_POLL: begin
                      if (prdata_i[1]) begin
`ifdef I2C_SEQ_TIMEOUT_EN
                        poll_cnt <= '0;
`endif
                        // NACK short-circuits the remaining ops straight to an error response.
                        if (prdata_i[2] || op_last) begin
                          state       <= S_RESP;
                          rsp_valid_o <= 1'b1;
                          rsp_err_o   <= prdata_i[2];
                          rsp_rdata_o <= '0;
                        end else begin
                          step <= step + 3'd1;
                        end
                      end
`ifdef I2C_SEQ_TIMEOUT_EN
                      else if (poll_cnt == PCW'(POLL_LIM - 1)) begin
                        poll_cnt <= '0;
                        abort_r  <= 1'b1;
                      end else begin
                        poll_cnt <= poll_cnt + 1'b1;
                      end
`endif
                    end
                    OP_RD: begin
                      state       <= S_RESP;
                      rsp_valid_o <= 1'b1;
                      rsp_err_o   <= 1'b0;
                      rsp_rdata_o <= prdata_i;
                    end
                    default: step <= step + 3'd1;
                  endcase
                end
              end
            end
          endcase
        end
      endcase
    end
  end
endmodule

// File: tb/tb_i2c_apb_sequencer.sv
// Directed bench for i2c_apb_sequencer: APB slave model plus scoreboards of expected transfers and responses.
module tb_i2c_apb_sequencer;
  logic       pclk = 1'b0;
  logic       preset = 1'b1;
  logic       req_valid = 1'b0, req_ready, req_rw = 1'b0;
  logic [6:0] req_slv = '0;
  logic [7:0] req_reg = '0, req_wdata = '0;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata, paddr, pwdata, prdata;
  logic       pwrite, psel, penable, pready;

  int total = 0, bad = 0;
  logic [16:0] apb_q[$];
  logic [8:0]  rsp_q[$];
  logic [7:0]  st_script[$];
  logic [7:0]  st_default = 8'h02, rx_data = 8'h00;
  int          st_reads = 0, st_base = 0, stall_cycles = 0, stall_cnt = 0;
  logic        chk_apb = 1'b1;
  logic [16:0] setup_snap = '0;

  i2c_apb_sequencer #(.DATA_SIZE(8), .ADDR_SIZE(8), .PRESCALE_VAL(8'd4), .POLL_LIMIT(8)) dut (
    .pclk_i(pclk), .preset_i(preset),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_rw_i(req_rw),
    .req_slave_addr_i(req_slv), .req_reg_addr_i(req_reg), .req_wdata_i(req_wdata),
    .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err),
    .paddr_o(paddr), .pwrite_o(pwrite), .psel_o(psel), .penable_o(penable),
    .pwdata_o(pwdata), .prdata_i(prdata), .pready_i(pready));

  initial forever #5 pclk = ~pclk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // APB slave: STATUS replies follow a script, then a default; pready stalls stall_cycles per ACCESS.
  assign pready = !(psel && penable) || (stall_cnt >= stall_cycles);
  always_comb begin
    prdata = 8'h00;
    if (paddr == 8'h05)
      prdata = (st_reads - st_base < st_script.size()) ? st_script[st_reads - st_base] : st_default;
    else if (paddr == 8'h04)
      prdata = rx_data;
  end
  always @(posedge pclk) begin
    if (psel && penable) stall_cnt <= pready ? 0 : stall_cnt + 1;
    if (psel && penable && pready && !pwrite && paddr == 8'h05) st_reads <= st_reads + 1;
  end

  // Monitors sample on the falling edge, away from DUT updates.
  always @(negedge pclk) begin
    if (psel && !penable) setup_snap <= {pwrite, paddr, pwdata};
    if (psel && penable) chk("access_hold", {15'd0, pwrite, paddr, pwdata}, {15'd0, setup_snap});
    if (psel && penable && pready && chk_apb) begin
      if (apb_q.size() == 0) chk("apb_unexpected", {15'd0, pwrite, paddr, pwdata}, 32'hFFFF_FFFF);
      else chk("apb_xfer", {15'd0, pwrite, paddr, pwrite ? pwdata : 8'h00}, {15'd0, apb_q.pop_front()});
    end
    if (rsp_valid) begin
      chk("rsp_ready_low", {31'd0, req_ready}, 32'd0);
      if (rsp_q.size() == 0) chk("rsp_unexpected", {23'd0, rsp_err, rsp_rdata}, 32'hFFFF_FFFF);
      else chk("rsp", {23'd0, rsp_err, rsp_rdata}, {23'd0, rsp_q.pop_front()});
    end
  end

  task automatic push_w(input logic [7:0] a, input logic [7:0] d); apb_q.push_back({1'b1, a, d}); endtask
  task automatic push_r(input logic [7:0] a); apb_q.push_back({1'b0, a, 8'h00}); endtask

  task automatic set_status(input logic [7:0] dflt);
    st_base = st_reads;
    st_default = dflt;
  endtask

  task automatic do_req(input logic rw, input logic [6:0] s, input logic [7:0] r, input logic [7:0] d);
    int n = 0;
    @(negedge pclk);
    req_valid = 1'b1; req_rw = rw; req_slv = s; req_reg = r; req_wdata = d;
    while (!req_ready && n < 500) begin @(negedge pclk); n++; end
    chk("accept", {31'd0, req_ready}, 32'd1);
    @(posedge pclk);
    #1 req_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!(apb_q.size() == 0 && rsp_q.size() == 0 && req_ready) && n < 2000) begin
      @(negedge pclk); n++;
    end
    chk(tag, {31'd0, n < 2000}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(negedge pclk);
    chk("rst_psel", {31'd0, psel}, 0);
    chk("rst_penable", {31'd0, penable}, 0);
    chk("rst_ready", {31'd0, req_ready}, 0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 0);
    chk("rst_paddr_pwdata", {16'd0, paddr, pwdata}, 0);
    chk("rst_rsp_data", {23'd0, rsp_err, rsp_rdata}, 0);

    // INIT: PRESCALE write, ready rises on the third edge after release.
    push_w(8'h00, 8'h04);
    preset = 1'b0;
    repeat (2) @(posedge pclk);
    #1 chk("init_ready_low", {31'd0, req_ready}, 0);
    @(posedge pclk);
    #1 chk("init_ready_high", {31'd0, req_ready}, 1);
    wait_idle("init_done");

    // Register write, done on the third poll.
    st_script = '{8'h01, 8'h01, 8'h02};
    set_status(8'h02);
    push_w(8'h02, 8'hA0); push_w(8'h03, 8'h10); push_w(8'h03, 8'hA5); push_w(8'h01, 8'h01);
    push_r(8'h05); push_r(8'h05); push_r(8'h05);
    rsp_q.push_back({1'b0, 8'h00});
    do_req(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_idle("wr_done");

    // Register read.
    st_script = '{8'h02, 8'h02};
    set_status(8'h02);
    rx_data = 8'h3C;
    push_w(8'h02, 8'hA0); push_w(8'h03, 8'h22); push_w(8'h01, 8'h05); push_r(8'h05);
    push_w(8'h02, 8'hA1); push_w(8'h01, 8'h03); push_r(8'h05); push_r(8'h04);
    rsp_q.push_back({1'b0, 8'h3C});
    do_req(1'b1, 7'h50, 8'h22, 8'h00);
    wait_idle("rd_done");

    // NACK on first poll of a read: remaining ops skipped.
    st_script = '{8'h06};
    set_status(8'h02);
    push_w(8'h02, 8'h66); push_w(8'h03, 8'h01); push_w(8'h01, 8'h05); push_r(8'h05);
    rsp_q.push_back({1'b1, 8'h00});
    do_req(1'b1, 7'h33, 8'h01, 8'h00);
    wait_idle("rd_nack_done");

    // NACK on a write.
    st_script = '{8'h01, 8'h06};
    set_status(8'h02);
    push_w(8'h02, 8'hFE); push_w(8'h03, 8'h80); push_w(8'h03, 8'h00); push_w(8'h01, 8'h01);
    push_r(8'h05); push_r(8'h05);
    rsp_q.push_back({1'b1, 8'h00});
    do_req(1'b0, 7'h7F, 8'h80, 8'h00);
    wait_idle("wr_nack_done");

    // pready held low 5 cycles per ACCESS.
    stall_cycles = 5;
    st_script = '{8'h02};
    set_status(8'h02);
    push_w(8'h02, 8'h02); push_w(8'h03, 8'h55); push_w(8'h03, 8'hC3); push_w(8'h01, 8'h01);
    push_r(8'h05);
    rsp_q.push_back({1'b0, 8'h00});
    do_req(1'b0, 7'h01, 8'h55, 8'hC3);
    wait_idle("stall_done");
    stall_cycles = 0;

`ifdef I2C_SEQ_TIMEOUT_EN
    // STATUS stuck busy: 8 polls, abort write, error response.
    st_script = {};
    set_status(8'h01);
    push_w(8'h02, 8'h42); push_w(8'h03, 8'h07); push_w(8'h03, 8'h5A); push_w(8'h01, 8'h01);
    for (int i = 0; i < 8; i++) push_r(8'h05);
    push_w(8'h01, 8'h00);
    rsp_q.push_back({1'b1, 8'h00});
    do_req(1'b0, 7'h21, 8'h07, 8'h5A);
    wait_idle("timeout_done");
`endif

    // Reset during a stuck poll: APB drops at once, INIT re-runs.
    st_script = {};
    set_status(8'h01);
    chk_apb = 1'b0;
    do_req(1'b0, 7'h10, 8'h20, 8'h30);
    begin
      int n = 0;
      while (!(psel && paddr == 8'h05) && n < 200) begin @(negedge pclk); n++; end
      chk("poll_seen", {31'd0, n < 200}, 32'd1);
    end
    #2 preset = 1'b1;
    #1 chk("midrst_psel", {30'd0, psel, penable}, 0);
    chk("midrst_ready", {31'd0, req_ready}, 0);
    apb_q.delete();
    chk_apb = 1'b1;
    set_status(8'h02);
    push_w(8'h00, 8'h04);
    @(negedge pclk);
    preset = 1'b0;
    wait_idle("reinit_done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/i2c_apb_sequencer.md
Name: i2c_apb_sequencer

Overview:
- APB master that runs single-byte register transactions on the I2C master core (APB slave, 8-bit addr/data) on behalf of a simple request/response client.
- Each request becomes a fixed sequence of APB writes, status polls and reads. The client never touches the core's register map.
- Sits between the system-side client and the I2C master's APB port, in the `pclk_i` domain.

Parameters:
- DATA_SIZE, 8, APB data width.
- ADDR_SIZE, 8, APB address width.
- PRESCALE_VAL, 8'd4, value written to the PRESCALE register once after reset.
- POLL_LIMIT, 1024, maximum STATUS reads per wait phase (timeout feature only).

Ports:
- pclk_i  in  1  APB/sequencer clock.
- preset_i  in  1  asynchronous active-high reset.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  sequencer can accept a request.
- req_rw_i  in  1  0 = register write, 1 = register read.
- req_slave_addr_i  in  7  I2C 7-bit slave address.
- req_reg_addr_i  in  8  slave register (sub-)address.
- req_wdata_i  in  DATA_SIZE  write data.
- rsp_valid_o  out  1  one-cycle response strobe.
- rsp_rdata_o  out  DATA_SIZE  read data; 0 for writes.
- rsp_err_o  out  1  NACK or timeout; valid with rsp_valid_o.
- paddr_o  out  ADDR_SIZE  APB address.
- pwrite_o  out  1  APB write.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwdata_o  out  DATA_SIZE  APB write data.
- prdata_i  in  DATA_SIZE  APB read data.
- pready_i  in  1  APB ready.

Behaviour:
- Core register map:
  - 0x00 PRESCALE
  - 0x01 CMD: bit0 go, bit1 rd, bit2 no_stop
  - 0x02 SLV_ADDR: {addr7, r/w}
  - 0x03 TX_DATA: push to TX FIFO
  - 0x04 RX_DATA
  - 0x05 STATUS: bit0 busy, bit1 done (clear-on-read), bit2 nack
- Reset values: all outputs 0, including req_ready_o, psel_o, penable_o, paddr_o, pwdata_o, rsp_*.
- Reset mid-operation aborts everything immediately: psel_o and penable_o drop asynchronously.
- APB transfer:
  - SETUP cycle: psel=1, penable=0, addr/write/wdata stable.
  - ACCESS cycle(s): penable=1, held until pready_i=1.
  - One idle cycle (psel=0) between transfers.
  - prdata_i is captured in the cycle where pready_i=1.
  - With pready_i tied high, each transfer takes 3 cycles.
- Top-level FSM:
  - INIT: write PRESCALE=PRESCALE_VAL, then go to IDLE.
  - IDLE: req_ready_o=1. On req_valid_i & req_ready_o, register the request, drop req_ready_o next cycle and go to EXEC.
  - EXEC: step counter through the op list below.
  - RESP: rsp_valid_o=1 for exactly one cycle with rdata/err, then back to IDLE.
- Write op list:
  - SLV_ADDR={a,0}, TX_DATA=reg, TX_DATA=wdata, CMD=0x01.
  - POLL until done.
  - Go to RESP.
- Read op list:
  - SLV_ADDR={a,0}, TX_DATA=reg, CMD=0x05 (no_stop), POLL.
  - SLV_ADDR={a,1}, CMD=0x03, POLL.
  - RX_DATA read, then RESP.
- POLL:
  - Repeated STATUS reads until bit1=1.
  - If that read also shows bit2=1: skip the remaining ops, set rsp_err_o=1, rsp_rdata_o=0, go to RESP.
- Requests are not queued. req_valid_i while busy is ignored, and the client must hold it until accepted.
- The same cycle as rsp_valid_o is not an accept cycle. The earliest next accept is the cycle after RESP.
- Parameter edges:
  - POLL_LIMIT is treated as at least 1.
  - PRESCALE_VAL is truncated to DATA_SIZE bits.

Optional Feature:
- Macro I2C_SEQ_TIMEOUT_EN.
- Defined:
  - A POLL phase exceeding POLL_LIMIT STATUS reads ends with rsp_err_o=1 and rsp_rdata_o=0.
  - The sequencer then writes CMD=0x00 once, to abort the core, before RESP.
- Undefined:
  - POLL waits indefinitely.
  - No counter logic is generated.

Test Plan:
- Reset release, pready tied 1 -> first transfer is a write of 0x04 to addr 0x00; req_ready_o rises after that transfer completes.
- Write request (slave 0x50, reg 0x10, data 0xA5), core returns done after 3 polls -> APB writes 0xA0@0x02, 0x10@0x03, 0xA5@0x03, 0x01@0x01, then 3 STATUS reads; one rsp_valid_o with err=0, rdata=0.
- Read request (slave 0x50, reg 0x22), RX_DATA=0x3C -> CMD writes 0x05 then 0x03, SLV_ADDR writes 0xA0 then 0xA1; response rdata=0x3C, err=0.
- STATUS returns 0x06 on the first poll -> no further ops, response err=1, rdata=0.
- pready_i held low 5 cycles in ACCESS -> psel/penable/paddr/pwdata stay stable; transfer completes on the first pready=1 cycle.
- With I2C_SEQ_TIMEOUT_EN and POLL_LIMIT=8, STATUS stuck at 0x01 -> exactly 8 STATUS reads, one 0x00@0x01 write, response err=1; assert preset_i mid-poll -> psel_o=0 immediately, INIT re-runs.
